// File: rtl/gf180_ram_64x8_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of one
// gf180_ram_64x8_wrapper single-port SRAM macro.
// After reset the macro CEN is held high for INIT_CYCLES cycles (bring-up).
// The arbiter then time-shares the macro between two requesters.
// All macro-side outputs are registered.
// Read data returns three cycles after the grant on a per-port valid strobe.
// Optional feature macro: RAM_ARB_CLEAR_EN.
// When it is defined, the whole array is zeroed after INIT and before RUN.
module gf180_ram_64x8_arbiter #(
    parameter int AW          = 6,
    parameter int DW          = 8,
    parameter int INIT_CYCLES = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wmask0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wmask1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          ready,
    output logic          ram_cen,
    output logic          ram_gwen,
    output logic [DW-1:0] ram_wen,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    init_cnt;
    logic          ptr;
    logic          grant_any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [DW-1:0] sel_wmask;
    logic          p1_valid;
    logic          p1_owner;
    logic          p2_valid;
    logic          p2_owner;
`ifdef RAM_ARB_CLEAR_EN
    logic [AW-1:0] clr_addr;
`endif

    assign ready = (state == RUN);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: INIT holds CEN high, then (optionally) CLEAR, then RUN forever.
    always_comb begin
        state_next = state;
        case (state)
            INIT: begin
                if (init_cnt == 8'(INIT_CYCLES - 1)) begin
`ifdef RAM_ARB_CLEAR_EN
                    state_next = CLEAR;
`else
                    state_next = RUN;
`endif
                end
            end
`ifdef RAM_ARB_CLEAR_EN
            CLEAR: begin
                if (clr_addr == {AW{1'b1}}) begin
                    state_next = RUN;
                end
            end
`endif
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Counts the CEN-high bring-up cycles while in INIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 8'd1;
        end else begin
            init_cnt <= '0;
        end
    end

`ifdef RAM_ARB_CLEAR_EN
    // Walks the clear address upwards, one word per cycle, while in CLEAR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end else begin
            clr_addr <= '0;
        end
    end
`endif

    // Round-robin arbitration.
    // With both ports requesting, the one granted less recently wins.
    always_comb begin
        gnt0      = ready && req0 && (!req1 || !ptr);
        gnt1      = ready && req1 && (!req0 || ptr);
        grant_any = gnt0 || gnt1;
        sel_we    = gnt1 ? we1    : we0;
        sel_addr  = gnt1 ? addr1  : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
        sel_wmask = gnt1 ? wmask1 : wmask0;
    end

    // Pointer prefers the port that did not receive the latest grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end

    // Macro input registers.
    // Loaded on a grant (or a clear write); otherwise the macro is deselected.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ram_cen  <= 1'b1;
            ram_gwen <= 1'b1;
            ram_wen  <= '1;
            ram_a    <= '0;
            ram_d    <= '0;
        end else begin
            if (grant_any) begin
                ram_cen <= 1'b0;
                ram_a   <= sel_addr;
                if (sel_we) begin
                    ram_gwen <= 1'b0;
                    ram_wen  <= ~sel_wmask;
                    ram_d    <= sel_wdata;
                end else begin
                    ram_gwen <= 1'b1;
                    ram_wen  <= '1;
                end
            end else begin
                ram_cen  <= 1'b1;
                ram_gwen <= 1'b1;
                ram_wen  <= '1;
            end
`ifdef RAM_ARB_CLEAR_EN
            if (state == CLEAR) begin
                ram_cen  <= 1'b0;
                ram_gwen <= 1'b0;
                ram_wen  <= '0;
                ram_a    <= clr_addr;
                ram_d    <= '0;
            end
`endif
        end
    end

    // Two-deep owner/valid pipeline.
    // It tags each read so that the returned data reaches the port that issued it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p1_valid <= 1'b0;
            p1_owner <= 1'b0;
            p2_valid <= 1'b0;
            p2_owner <= 1'b0;
        end else begin
            p1_valid <= (gnt0 && !we0) || (gnt1 && !we1);
            p1_owner <= gnt1;
            p2_valid <= p1_valid;
            p2_owner <= p1_owner;
        end
    end

    // Captures macro Q into the owning port and raises its one-cycle valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= p2_valid && !p2_owner;
            rvalid1 <= p2_valid && p2_owner;
            if (p2_valid && !p2_owner) begin
                rdata0 <= ram_q;
            end
            if (p2_valid && p2_owner) begin
                rdata1 <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_gf180_ram_64x8_arbiter.sv
// Self-checking bench for gf180_ram_64x8_arbiter.
// A behavioural SRAM model stands in for the macro.
// A reference memory plus a scoreboard queue predict every read return.
// Build with RAM_ARB_CLEAR_EN defined to exercise the clear-after-init variant.
module tb_gf180_ram_64x8_arbiter;

   localparam int AW          = 6;
   localparam int DW          = 8;
   localparam int INIT_CYCLES = 4;

   typedef struct {
      bit         port;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RST;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wmask0, wdata1, wmask1;
   logic          gnt0, gnt1, rvalid0, rvalid1, ready;
   logic [DW-1:0] rdata0, rdata1;
   logic          ram_cen, ram_gwen;
   logic [DW-1:0] ram_wen, ram_d;
   logic [DW-1:0] ram_q = '0;
   logic [AW-1:0] ram_a;

   logic [7:0] mem     [64];
   logic [7:0] ref_mem [64];
   bit         mem_loaded = 1'b0;
   bit         ref_loaded = 1'b0;
   exp_t       sb[$];
   exp_t       mon_e;
   int         cyc    = 0;
   int         errors = 0;
   int         checks = 0;

   gf180_ram_64x8_arbiter #(.AW(AW), .DW(DW), .INIT_CYCLES(INIT_CYCLES)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .wmask0(wmask0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .wmask1(wmask1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ready(ready), .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
      .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
   );

   // Free-running clock with a 10 ns period.
   always #5 CLK = ~CLK;

   // Cycle counter used to measure read latency.
   always @(posedge CLK) cyc <= cyc + 1;

   // Single-port SRAM model.
   // Its contents are preloaded on the first edge and survive DUT resets.
   always @(posedge CLK) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 3);
         mem_loaded <= 1'b1;
      end else if (!ram_cen) begin
         if (!ram_gwen) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
         else           ram_q      <= mem[ram_a];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor.
   // Grants update the reference memory or queue an expected read.
   // Each rvalid is matched against the oldest queued read.
   always @(negedge CLK) begin
      if (!ref_loaded) begin
         for (int i = 0; i < 64; i++) begin
`ifdef RAM_ARB_CLEAR_EN
            ref_mem[i] = 8'h00;
`else
            ref_mem[i] = 8'(i * 7 + 3);
`endif
         end
         ref_loaded = 1'b1;
      end
      if (rvalid0 || rvalid1) begin
         if (sb.size() == 0) begin
            checkOutput("rvalid_unexpected", {rvalid1, rvalid0}, 0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("rvalid_port", {rvalid1, rvalid0}, mon_e.port ? 2'b10 : 2'b01);
            checkOutput("rdata", mon_e.port ? rdata1 : rdata0, mon_e.data);
            checkOutput("rvalid_latency", cyc - mon_e.cyc, 3);
         end
      end
      if (sb.size() > 0 && (cyc - sb[0].cyc) > 3) begin
         checkOutput("rvalid_missing", cyc - sb[0].cyc, 3);
         void'(sb.pop_front());
      end
      if (gnt0) begin
         if (we0) ref_mem[addr0] = (ref_mem[addr0] & ~wmask0) | (wdata0 & wmask0);
         else     sb.push_back('{port: 1'b0, data: ref_mem[addr0], cyc: cyc});
      end
      if (gnt1) begin
         if (we1) ref_mem[addr1] = (ref_mem[addr1] & ~wmask1) | (wdata1 & wmask1);
         else     sb.push_back('{port: 1'b1, data: ref_mem[addr1], cyc: cyc});
      end
   end

   // One isolated access on a single port.
   // Checks the grant and the macro registers loaded by it.
   task automatic applyStimulus(input bit port, input bit we, input logic [5:0] addr,
                                input logic [7:0] wdata, input logic [7:0] wmask);
      logic [7:0] exp_wen;
      exp_wen = we ? ~wmask : 8'hFF;
      if (!port) begin
         req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; wmask0 = wmask;
      end else begin
         req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; wmask1 = wmask;
      end
      @(negedge CLK);
      checkOutput("gnt", port ? gnt1 : gnt0, 1);
      checkOutput("gnt_other", port ? gnt0 : gnt1, 0);
      @(posedge CLK); #1;
      req0 = 0; req1 = 0;
      @(negedge CLK);
      checkOutput("acc_cen", ram_cen, 0);
      checkOutput("acc_a", ram_a, addr);
      checkOutput("acc_gwen", ram_gwen, !we);
      checkOutput("acc_wen", ram_wen, exp_wen);
      if (we) checkOutput("acc_d", ram_d, wdata);
      @(posedge CLK); #1;
   endtask

   // Bring-up hold after a reset release.
   // CEN stays high with no grants, then ready rises.
   task automatic checkInit();
      for (int i = 0; i < INIT_CYCLES; i++) begin
         @(negedge CLK);
         checkOutput("init_ready", ready, 0);
         checkOutput("init_cen", ram_cen, 1);
         checkOutput("init_gnt0", gnt0, 0);
      end
`ifdef RAM_ARB_CLEAR_EN
      for (int i = 0; i < 64; i++) begin
         @(negedge CLK);
         checkOutput("clear_ready", ready, 0);
      end
`endif
      @(negedge CLK);
      checkOutput("ready_up", ready, 1);
   endtask

   // Directed test sequence.
   initial begin
      RST = 1;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; wmask0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; wmask1 = '0;
      repeat (2) @(posedge CLK);
      #1;
      req0 = 1; we0 = 0; addr0 = 6'h2A;
      @(negedge CLK);
      checkOutput("rst_cen", ram_cen, 1);
      checkOutput("rst_gwen", ram_gwen, 1);
      checkOutput("rst_wen", ram_wen, 8'hFF);
      checkOutput("rst_a", ram_a, 0);
      checkOutput("rst_d", ram_d, 0);
      checkOutput("rst_ready", ready, 0);
      checkOutput("rst_gnt0", gnt0, 0);
      checkOutput("rst_rvalid", {rvalid1, rvalid0}, 0);
      checkOutput("rst_rdata", {rdata1, rdata0}, 0);
      @(posedge CLK); #1;
      RST = 0;
      checkInit();
      checkOutput("first_gnt0", gnt0, 1);
      @(posedge CLK); #1;
      req0 = 0;

      $display("[TB] write then read back on port 0");
      applyStimulus(0, 1, 6'h05, 8'hA5, 8'hFF);
      applyStimulus(0, 0, 6'h05, 8'h00, 8'h00);
      @(negedge CLK);
      checkOutput("idle_cen", ram_cen, 1);
      checkOutput("idle_a_hold", ram_a, 6'h05);
      @(posedge CLK); #1;

      $display("[TB] write with empty mask leaves the word unchanged");
      applyStimulus(0, 1, 6'h05, 8'h00, 8'h00);
      applyStimulus(0, 0, 6'h05, 8'h00, 8'h00);

      $display("[TB] partial write on port 1");
      applyStimulus(1, 1, 6'h10, 8'hFF, 8'hFF);
      applyStimulus(1, 1, 6'h10, 8'h00, 8'h0F);
      applyStimulus(1, 0, 6'h10, 8'h00, 8'h00);
      repeat (4) @(posedge CLK);
      #1;

      $display("[TB] both ports requesting for six cycles");
      req0 = 1; we0 = 0; addr0 = 6'h05;
      req1 = 1; we1 = 0; addr1 = 6'h10;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         checkOutput("rr_gnt0", gnt0, (i % 2) == 0);
         checkOutput("rr_gnt1", gnt1, (i % 2) == 1);
         @(posedge CLK); #1;
      end
      req0 = 0; req1 = 0;
      repeat (5) @(posedge CLK);
      #1;

      $display("[TB] reset pulsed behind a pending read");
      req0 = 1; we0 = 0; addr0 = 6'h3F;
      @(negedge CLK);
      checkOutput("pre_rst_gnt0", gnt0, 1);
      @(posedge CLK); #1;
      req0 = 0;
      RST  = 1;
      sb.delete();
      @(negedge CLK);
      checkOutput("mid_rst_cen", ram_cen, 1);
      checkOutput("mid_rst_ready", ready, 0);
      checkOutput("mid_rst_rvalid0", rvalid0, 0);
      @(posedge CLK); #1;
      RST = 0;
      checkInit();
      @(posedge CLK); #1;

      $display("[TB] cross-port write then read back to back");
      req1 = 1; we1 = 1; addr1 = 6'h01; wdata1 = 8'h3C; wmask1 = 8'hFF;
      @(negedge CLK);
      checkOutput("xw_gnt1", gnt1, 1);
      @(posedge CLK); #1;
      req1 = 0;
      req0 = 1; we0 = 0; addr0 = 6'h01;
      @(negedge CLK);
      checkOutput("xr_gnt0", gnt0, 1);
      @(posedge CLK); #1;
      req0 = 0;

      repeat (6) @(posedge CLK);
      @(negedge CLK);
      checkOutput("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gf180_ram_64x8_arbiter.md
Name: gf180_ram_64x8_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of one gf180_ram_64x8_wrapper SRAM macro. After reset it performs the macro's chip-enable bring-up: CEN is held high, then released low, which arms the macro. It then time-shares the single-port macro between two requesters, each with its own read/write port. Registered macro-side outputs; read data returned on a per-port valid strobe.

Parameters:
AW, 6, address width (64 words)
DW, 8, data width; per-bit write mask width equals DW
INIT_CYCLES, 4, cycles CEN held high after reset before the first access, range 2..255

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
req0  input  1  port 0 request, held until gnt0
we0  input  1  port 0: 1 = write, 0 = read
addr0  input  AW  port 0 word address
wdata0  input  DW  port 0 write data
wmask0  input  DW  port 0 per-bit write mask, 1 = write bit
gnt0  output  1  port 0 accepted this cycle (combinational)
rvalid0  output  1  port 0 read data valid, 1-cycle pulse
rdata0  output  DW  port 0 read data
req1/we1/addr1/wdata1/wmask1/gnt1/rvalid1/rdata1  same as port 0, for port 1
ready  output  1  init complete; requests can be granted
ram_cen  output  1  macro CEN, active low
ram_gwen  output  1  macro GWEN, 0 = write
ram_wen  output  DW  macro WEN, active-low per bit
ram_a  output  AW  macro address
ram_d  output  DW  macro write data
ram_q  input  DW  macro Q

Behaviour:
- Reset values: ram_cen=1, ram_gwen=1, ram_wen=all 1, ram_a=0, ram_d=0, gnt*=0, rvalid*=0, rdata*=0, ready=0, round-robin pointer = port 0 preferred.
- FSM states:
  - INIT: counter runs; ram_cen=1 for INIT_CYCLES cycles, then go to RUN. This CEN 1->0 sequence is the bring-up the macro needs.
  - RUN: ready=1.
- Arbitration (RUN only): gnt_x = req_x && ready && wins.
  - Only one requesting -> it wins.
  - Both requesting -> the port not granted most recently wins; the pointer updates on every grant.
  - Back-to-back grants allowed every cycle; full throughput is one access per cycle.
- Grant edge (end of gnt cycle) loads the macro registers:
  - ram_cen=0, ram_a=addr.
  - Write: ram_gwen=0, ram_wen=~wmask, ram_d=wdata.
  - Read: ram_gwen=1, ram_wen=all 1, ram_d unchanged.
- No grant in a cycle: next edge sets ram_cen=1, ram_gwen=1, ram_wen=all 1; address/data hold.
- Write with wmask=0: granted normally, drives gwen=0 with wen=all 1; the macro is unchanged.
- Read latency: gnt in cycle n -> macro clocked at end of n+1 -> ram_q captured into rdata_x at end of n+2 -> rvalid_x=1 in cycle n+3 for exactly one cycle.
  - rdata_x holds its value until the next capture for that port.
  - A 2-deep owner/valid pipeline tags each access with its port id so rvalid goes to the correct port.
  - Writes produce no rvalid.
- Same-address write then read back-to-back (either port): the read returns the new data because the macro serialises accesses in order. No bypass logic.
- req_x while not ready: no grant; the request is held by the requester.
- RST asserted mid-operation: all registers go to reset values immediately, including pending rvalids, which are dropped. INIT is re-entered and the full INIT_CYCLES hold repeats.
- Timing: macro min clock period is 55.6 ns; CLK is constrained accordingly elsewhere.

Optional Feature:
RAM_ARB_CLEAR_EN
- Defined: after INIT, a CLEAR state writes 0 to all 2^AW words, one word per cycle, ascending address, ram_wen=all 0, ram_gwen=0. This takes 2^AW cycles. ready stays 0 until the last write is issued, then the FSM goes to RUN.
- Reset during CLEAR restarts from INIT.
- Undefined: INIT goes directly to RUN; memory contents are whatever the macro holds.

Test Plan:
- Reset release -> ram_cen=1 for exactly 4 cycles, ready=1 at cycle 4, no gnt before it; with RAM_ARB_CLEAR_EN, ready is instead high after 4+64 cycles and a read of addr 0x2A returns 0x00.
- Port0 write addr=0x05, wdata=0xA5, wmask=0xFF; then port0 read addr=0x05 -> rvalid0 exactly 3 cycles after that gnt0, rdata0=0xA5, rvalid1 stays 0.
- Partial write: addr 0x10 holds 0xFF; port1 write wdata=0x00, wmask=0x0F; read back -> 0xF0; ram_wen observed 0xF0 during the write access.
- req0 and req1 both held high for 6 cycles -> grants alternate 0,1,0,1,0,1 (pointer starts at 0); one access per cycle; each read's rvalid lands on the issuing port.
- Port0 read addr 0x3F issued, RST pulsed in cycle n+1 -> no rvalid0 ever; INIT hold repeats; ram_cen=1 throughout.
- Port1 write addr 0x01 = 0x3C, port0 read 0x01 granted the next cycle -> rdata0=0x3C.
